// File: rtl/tick_sched.sv
// tick_sched: multi-channel interval timer driven by a shared prescaler.
// Channel expiries produce one-cycle tick pulses and queue events. Pending
// events are drained one per cycle through a round-robin arbiter that
// presents them on a registered valid/ready port.
module tick_sched #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned PRE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [PRE_W-1:0]        prescale,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [W-1:0]            cfg_period,
  input  logic                    cfg_oneshot,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         stop,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         overrun,
  output logic                    evt_valid,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  input  logic                    evt_ready
);

  localparam int unsigned CH_W = $clog2(N_CH);

  typedef enum logic {StIdle, StRun} ch_state_e;

  // Prescaler
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             base_tick;

  // Per-channel state
  ch_state_e        st_q     [N_CH];
  ch_state_e        st_d     [N_CH];
  logic [W-1:0]     cnt_q    [N_CH];
  logic [W-1:0]     cnt_d    [N_CH];
  logic [W-1:0]     period_q [N_CH];
  logic [W-1:0]     period_d [N_CH];
  logic [W-1:0]     term     [N_CH];
  logic [N_CH-1:0]  oneshot_q, oneshot_d;
  logic [N_CH-1:0]  tick_q, tick_d;

  // Event bookkeeping
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  ovr_q, ovr_d;
  logic [N_CH-1:0]  acc_mask;
  logic [N_CH-1:0]  avail;
  logic             acc;

  // Arbiter / output register
  logic             evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  grant_ch;
  logic             found;
  int unsigned      idx;

  // Free-running prescaler; a counter above a freshly lowered limit wraps at once.
  always_comb begin
    base_tick = (pre_q >= prescale);
    pre_d     = base_tick ? '0 : pre_q + PRE_W'(1);
  end

  // Channel FSMs: config writes, start/stop, counting and expiry detection.
  always_comb begin
    oneshot_d = oneshot_q;
    tick_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]     = st_q[i];
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      // Period 0 behaves as period 1.
      term[i]     = (period_q[i] == '0) ? '0 : period_q[i] - W'(1);

      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        period_d[i]  = cfg_period;
        oneshot_d[i] = cfg_oneshot;
      end

      if (stop[i]) begin
        st_d[i]  = StIdle;
        cnt_d[i] = '0;
      end else if (start[i]) begin
        st_d[i]  = StRun;
        cnt_d[i] = '0;
      end else if ((st_q[i] == StRun) && base_tick) begin
        if (cnt_q[i] >= term[i]) begin
          tick_d[i] = 1'b1;
          cnt_d[i]  = '0;
          if (oneshot_q[i]) begin
            st_d[i] = StIdle;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + W'(1);
        end
      end
    end
  end

  // Pending flags and sticky overrun; an expiry on the channel being accepted
  // re-arms pending without counting as an overrun.
  always_comb begin
    acc    = evt_valid_q && evt_ready;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < N_CH; i++) begin
      acc_mask[i] = acc && (evt_ch_q == CH_W'(i));
      if (acc_mask[i]) begin
        pend_d[i] = 1'b0;
      end
      if (tick_d[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !acc_mask[i]) begin
          ovr_d[i] = 1'b1;
        end
      end
      if (start[i] && !stop[i]) begin
        ovr_d[i] = 1'b0;
      end
    end
  end

  // Round-robin pick among pending channels, starting at ptr_q; the pointer
  // moves to one past each channel granted.
  always_comb begin
    avail    = pend_q & ~acc_mask;
    found    = 1'b0;
    grant_ch = '0;
    idx      = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (32'(ptr_q) + k) % N_CH;
      if (!found && avail[idx]) begin
        found    = 1'b1;
        grant_ch = CH_W'(idx);
      end
    end

    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    ptr_d       = ptr_q;
    // evt_ch only changes when nothing is presented or the current one is taken.
    if (!evt_valid_q || acc) begin
      evt_valid_d = found;
      if (found) begin
        evt_ch_d = grant_ch;
        ptr_d    = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      pre_q       <= '0;
      oneshot_q   <= '0;
      tick_q      <= '0;
      pend_q      <= '0;
      ovr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]     <= StIdle;
        cnt_q[i]    <= '0;
        period_q[i] <= W'(1);
      end
    end else begin
      pre_q       <= pre_d;
      oneshot_q   <= oneshot_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]     <= st_d[i];
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      busy[i] = (st_q[i] == StRun);
    end
    tick      = tick_q;
    overrun   = ovr_q;
    evt_valid = evt_valid_q;
    evt_ch    = evt_ch_q;
  end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed stimulus with a tick/event scoreboard checked by a monitor.
module tb_tick_sched;

  logic        clk = 1'b0;
  logic        rst_;
  logic [15:0] prescale;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_period;
  logic        cfg_oneshot;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [3:0]  tick;
  logic [3:0]  busy;
  logic [3:0]  overrun;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic        evt_ready;

  tick_sched #(
    .N_CH (4),
    .W    (32),
    .PRE_W(16)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .prescale   (prescale),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .busy       (busy),
    .overrun    (overrun),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_ready  (evt_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] vec;
  } tick_t;

  tick_t tq[$];
  int    eq[$];
  tick_t te;
  int    total = 0;
  int    bad = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic cfg(input int ch, input int per, input logic os);
    cfg_we      = 1'b1;
    cfg_ch      = 2'(ch);
    cfg_period  = 32'(per);
    cfg_oneshot = os;
    step(1);
    cfg_we      = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] sta, input logic [3:0] sto);
    start = sta;
    stop  = sto;
    step(1);
    start = '0;
    stop  = '0;
  endtask

  task automatic exp_tick(input int at, input logic [3:0] vec);
    tick_t t;
    t.at  = at;
    t.vec = vec;
    tq.push_back(t);
  endtask

  // Monitor: ticks against timed expectations, accepted events against order.
  always @(negedge clk) begin
    if (mon_en) begin
      while (tq.size() > 0 && tq[0].at < cyc) begin
        total++;
        bad++;
        $display("FAIL tick_missing: want %b at cyc %0d, not seen", tq[0].vec, tq[0].at);
        void'(tq.pop_front());
      end
      if (tq.size() > 0 && tq[0].at == cyc) begin
        te = tq.pop_front();
        chk("tick", 32'(tick), 32'(te.vec));
      end else if (tick !== 4'b0000) begin
        chk("tick_unexpected", 32'(tick), 32'd0);
      end
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (eq.size() == 0) begin
          chk("evt_unexpected", 32'(evt_valid), 32'd0);
        end else begin
          chk("evt_ch", 32'(evt_ch), 32'(eq.pop_front()));
        end
      end
    end
  end

  int k;

  initial begin
    rst_        = 1'b0;
    prescale    = '0;
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_period  = '0;
    cfg_oneshot = 1'b0;
    start       = '0;
    stop        = '0;
    evt_ready   = 1'b0;
    step(2);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evt_ch", 32'(evt_ch), 0);
    rst_   = 1'b1;
    mon_en = 1'b1;

    // Round-robin: four one-shot channels expiring together.
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) cfg(i, 4, 1'b1);
    pulse(4'b1111, 4'b0000);
    k = cyc;
    exp_tick(k + 4, 4'b1111);
    for (int i = 0; i < 4; i++) eq.push_back(i);
    chk("rr_busy", 32'(busy), 32'hf);
    for (int i = 0; i < 4; i++) begin
      wait_until(k + 5 + i);
      chk("rr_valid", 32'(evt_valid), 1);
      chk("rr_order", 32'(evt_ch), 32'(i));
    end
    wait_until(k + 9);
    chk("rr_drained", 32'(evt_valid), 0);
    chk("rr_oneshot_idle", 32'(busy), 0);
    // Pointer now 0; grant ch1 moves it to 2, so ch3 beats ch0 next.
    pulse(4'b0010, 4'b0000);
    k = cyc;
    exp_tick(k + 4, 4'b0010);
    eq.push_back(1);
    step(8);
    pulse(4'b1001, 4'b0000);
    k = cyc;
    exp_tick(k + 4, 4'b1001);
    eq.push_back(3);
    eq.push_back(0);
    wait_until(k + 5);
    chk("rr_ptr_first", 32'(evt_ch), 3);
    wait_until(k + 6);
    chk("rr_ptr_second", 32'(evt_ch), 0);
    step(4);

    // Periodic ch0, period 5, prescale 0.
    cfg(0, 5, 1'b0);
    pulse(4'b0001, 4'b0000);
    k = cyc;
    exp_tick(k + 5, 4'b0001);
    exp_tick(k + 10, 4'b0001);
    exp_tick(k + 15, 4'b0001);
    repeat (3) eq.push_back(0);
    chk("per_busy", 32'(busy), 1);
    wait_until(k + 6);
    chk("per_evt_valid", 32'(evt_valid), 1);
    chk("per_evt_ch", 32'(evt_ch), 0);
    wait_until(k + 16);
    pulse(4'b0000, 4'b0001);
    chk("per_stopped", 32'(busy), 0);
    step(8);

    // One-shot ch1, period 2, prescale 3: prescaler sits at 0 here.
    prescale = 16'd3;
    cfg(1, 2, 1'b1);
    step(2);
    pulse(4'b0010, 4'b0000);
    k = cyc;
    exp_tick(k + 8, 4'b0010);
    eq.push_back(1);
    chk("os_busy_start", 32'(busy[1]), 1);
    wait_until(k + 7);
    chk("os_busy_before", 32'(busy[1]), 1);
    wait_until(k + 8);
    chk("os_busy_fall", 32'(busy[1]), 0);
    step(3);
    prescale = 16'd0;
    step(2);

    // Overrun: ch2 period 1 with the consumer stalled.
    evt_ready = 1'b0;
    cfg(2, 1, 1'b0);
    pulse(4'b0100, 4'b0000);
    k = cyc;
    for (int i = 1; i <= 4; i++) exp_tick(k + i, 4'b0100);
    wait_until(k + 1);
    chk("ovr_first", 32'(overrun), 0);
    wait_until(k + 2);
    chk("ovr_set", 32'(overrun), 32'h4);
    chk("ovr_evt_valid", 32'(evt_valid), 1);
    chk("ovr_evt_ch", 32'(evt_ch), 2);
    wait_until(k + 4);
    chk("ovr_hold_ch", 32'(evt_ch), 2);
    chk("ovr_sticky", 32'(overrun), 32'h4);
    // Lengthen period and restart in one cycle; restart clears overrun.
    cfg_we      = 1'b1;
    cfg_ch      = 2'd2;
    cfg_period  = 32'd100;
    cfg_oneshot = 1'b0;
    start       = 4'b0100;
    step(1);
    cfg_we      = 1'b0;
    start       = '0;
    chk("ovr_cleared", 32'(overrun), 0);
    chk("ovr_busy", 32'(busy[2]), 1);
    eq.push_back(2);
    evt_ready = 1'b1;
    step(1);
    pulse(4'b0000, 4'b0100);
    step(2);
    chk("ovr_drained", 32'(evt_valid), 0);

    // Stop+start together: stop wins.
    cfg(0, 10, 1'b0);
    pulse(4'b0001, 4'b0000);
    k = cyc;
    step(3);
    pulse(4'b0001, 4'b0001);
    chk("ss_busy", 32'(busy[0]), 0);
    step(12);
    // Stop coincident with expiry: no tick, no event.
    cfg(0, 3, 1'b0);
    pulse(4'b0001, 4'b0000);
    k = cyc;
    wait_until(k + 2);
    pulse(4'b0000, 4'b0001);
    chk("se_busy", 32'(busy[0]), 0);
    step(4);
    chk("se_no_evt", 32'(evt_valid), 0);

    // Reset mid-operation with pending events and running channels.
    evt_ready = 1'b0;
    cfg(1, 2, 1'b0);
    cfg(3, 3, 1'b0);
    pulse(4'b1010, 4'b0000);
    k = cyc;
    exp_tick(k + 2, 4'b0010);
    exp_tick(k + 3, 4'b1000);
    exp_tick(k + 4, 4'b0010);
    wait_until(k + 4);
    chk("pre_rst_overrun", 32'(overrun), 32'h2);
    chk("pre_rst_valid", 32'(evt_valid), 1);
    chk("pre_rst_ch", 32'(evt_ch), 1);
    rst_ = 1'b0;
    step(1);
    chk("mid_rst_tick", 32'(tick), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_ch", 32'(evt_ch), 0);
    rst_ = 1'b1;
    step(1);
    chk("post_rst_tick", 32'(tick), 0);
    evt_ready = 1'b1;
    step(10);
    chk("post_rst_valid", 32'(evt_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);

    chk("tick_queue_empty", 32'(tq.size()), 0);
    chk("evt_queue_empty", 32'(eq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
